// File: rtl/mem_pkg.sv
// Shared command codes, FSM states and I/O address map for mem_responder.
package mem_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MILL   = 2'b11
  } mcmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_RAM  = 2'd0,
    SEL_LED  = 2'd1,
    SEL_SW   = 2'd2,
    SEL_NONE = 2'd3
  } rsel_e;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM, write-first, one-cycle read latency.
module ram_sync #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: RAM + LED/switch MMIO, access counters.
// Define MEM_ERR_EN to build the sticky error detector on err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int         RAM_WORDS = 256,
  parameter logic [8:0] LED_ADDR  = LED_ADDR_DEF,
  parameter logic [8:0] SW_ADDR   = SW_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] mdata,
  output logic        rd_valid,
  input  logic [7:0]  SW,
  output logic [7:0]  LEDR,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        err
);

  state_e      state_q;
  rsel_e       rsel_q, rsel_d;
  logic [8:0]  addr_q;
  logic [7:0]  sw1_q, sw2_q;
  logic [7:0]  led_q;
  logic [15:0] mdata_q, rd_cnt_q, wr_cnt_q;
  logic        rd_valid_q;
  logic [15:0] ram_dout, rdata;
  logic        is_ram, is_led, is_sw;
  logic        cmd_rd, cmd_wr, ram_we;
  logic        rd_hit, wr_hit;

  always_comb begin
    is_ram = mem_addr < 9'(RAM_WORDS);
    is_led = mem_addr == LED_ADDR;
    is_sw  = mem_addr == SW_ADDR;
    cmd_rd = mem_cmd == MREAD;
    cmd_wr = mem_cmd == MWRITE;
    ram_we = !reset && cmd_wr && is_ram;
    rd_hit = cmd_rd && (state_q != RD || mem_addr != addr_q);
    wr_hit = cmd_wr && (state_q != WR || mem_addr != addr_q);
    rsel_d = SEL_NONE;
    unique case (1'b1)
      is_ram:  rsel_d = SEL_RAM;
      is_led:  rsel_d = SEL_LED;
      is_sw:   rsel_d = SEL_SW;
      default: rsel_d = SEL_NONE;
    endcase
  end

  // Decode is registered with the read so data selection lines up with RAM dout
  always_comb begin
    rdata = 16'h0000;
    unique case (rsel_q)
      SEL_RAM:  rdata = ram_dout;
      SEL_LED:  rdata = {8'h00, led_q};
      SEL_SW:   rdata = {8'h00, sw2_q};
      default:  rdata = 16'h0000;
    endcase
  end

  ram_sync #(
    .DEPTH(RAM_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (mem_addr[7:0]),
    .din  (write_data),
    .dout (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rsel_q     <= SEL_NONE;
      addr_q     <= '0;
      sw1_q      <= '0;
      sw2_q      <= '0;
      led_q      <= '0;
      mdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      sw1_q      <= SW;
      sw2_q      <= sw1_q;
      addr_q     <= mem_addr;
      rsel_q     <= rsel_d;
      rd_valid_q <= state_q == RD;
      if (state_q == RD) mdata_q <= rdata;
      if (cmd_wr && is_led) led_q <= write_data[7:0];
      if (rd_hit && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_hit && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      unique case (mem_cmd)
        MREAD:   state_q <= RD;
        MWRITE:  state_q <= WR;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ERR_EN
  logic err_q;
  logic err_hit;

  always_comb begin
    err_hit = (mem_cmd == MILL)
            || (cmd_wr && is_sw)
            || ((cmd_rd || cmd_wr) && !is_ram && !is_led && !is_sw);
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mdata    = mdata_q;
  assign rd_valid = rd_valid_q;
  assign LEDR     = led_q;
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Target-side responder for the CPU memory interface. It samples mem_cmd and mem_addr every cycle and services each access. Storage is single-port synchronous RAM plus memory-mapped I/O: an LED output register and a synchronised switch input. Read data returns on mdata with one cycle of registered latency. Reads and writes are counted, and the block sits between the CPU core and the board I/O.

Parameters:
RAM_WORDS, 256, number of RAM words at addresses 0 to RAM_WORDS-1; must be ≤256.
LED_ADDR, 9'h100, address of the LED register (read/write).
SW_ADDR, 9'h140, address of the switch input (read-only).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
mem_cmd  in  2  00 = NONE, 01 = READ, 10 = WRITE, 11 = illegal
mem_addr  in  9  word address
write_data  in  16  store data (CPU datapath out)
mdata  out  16  registered read data
rd_valid  out  1  mdata updated by a READ sampled on the previous edge
SW  in  8  asynchronous board switches
LEDR  out  8  LED register
rd_count  out  16  read-access counter, saturating
wr_count  out  16  write-access counter, saturating
err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (sampled at posedge, has priority over everything):
  - mdata=0, rd_valid=0, LEDR=0, counters=0, err=0, state=IDLE, switch synchroniser=0.
  - RAM contents are kept.
  - Any access in the reset cycle is dropped.
- FSM states: IDLE, RD, WR. Next state is set by the mem_cmd sampled this edge:
  - NONE → IDLE; READ → RD; WRITE → WR.
  - illegal → IDLE, with no access.
- READ sampled at edge k:
  - mdata holds the selected data after edge k+1.
  - rd_valid=1 for that one cycle only.
- Read data by address:
  - RAM region: the RAM word.
  - LED_ADDR: {8'b0, LEDR}.
  - SW_ADDR: {8'b0, SW after the 2-flop synchroniser}.
  - Any other address: 16'h0000.
- READ held for several cycles: a new read is made every cycle. Address changes take effect the next cycle, so the IF1/IF2 double-cycle fetch returns the same word twice.
- WRITE sampled at edge k commits at edge k:
  - RAM region: writes the RAM word.
  - LED_ADDR: LEDR ← write_data[7:0].
  - SW_ADDR and unmapped addresses: write ignored.
- During WRITE: mdata holds its value and rd_valid=0.
- WRITE held for several cycles rewrites every cycle. This is idempotent when address and data are stable.
- Counters:
  - rd_count increments on entry to RD, or on a mem_addr change while staying in RD.
  - wr_count follows the same rule for WR.
  - A held command counts once.
  - Both counters saturate at 16'hFFFF.
- Read after write to the same address on consecutive cycles returns the new data; no bypass is needed because the write commits first.
- No stall or ready signal: every access completes at fixed latency.

Optional Feature:
Macro MEM_ERR_EN.
- Defined: err is set at the edge where any of these is sampled:
  - mem_cmd=11;
  - WRITE to SW_ADDR;
  - READ or WRITE to an unmapped address.
  err stays set until reset.
- Undefined: err is tied to 0 and the detection logic is not built.
- All other behaviour is identical in both builds.

Decomposition:
- Package mem_pkg holds:
  - command codes MNONE/MREAD/MWRITE;
  - state enum {IDLE, RD, WR};
  - default LED_ADDR and SW_ADDR constants.
- Sub-module ram_sync holds the single-port synchronous RAM:
  - ports: clk, we, addr[7:0], din[15:0], dout[15:0];
  - write-first, 1-cycle read.
- mem_responder contains the address decode, FSM, I/O registers and counters.

Test Plan:
- Reset, then WRITE addr 9'h005 data 16'hBEEF, then READ 9'h005 → mdata=16'hBEEF and rd_valid=1 exactly one cycle after the READ edge; wr_count=1, rd_count=1.
- WRITE LED_ADDR data 16'h12A5 → LEDR=8'hA5; READ LED_ADDR → mdata=16'h00A5.
- Set SW=8'h3C, wait 2 cycles, READ SW_ADDR → mdata=16'h003C. WRITE SW_ADDR → no change; err=1 when MEM_ERR_EN is defined, else 0.
- READ held 2 cycles at 9'h010, then moved to 9'h011 for 1 cycle → rd_count=2; data for both addresses appears in order.
- Reset asserted during the cycle of WRITE addr 9'h020 data 16'h1111 (RAM previously 16'h0000) → after reset, READ 9'h020 returns 16'h0000; LEDR=0 and counters=0.
- mem_cmd=11 at addr 9'h005 → RAM unchanged; err=1 with MEM_ERR_EN; state IDLE; counters unchanged.
